// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: shared constants, FSM states and access-decode helpers for the LSU.
package load_store_unit_pkg;
   localparam int XLEN = 32;
   localparam int LSU_TIMEOUT = 255;
   localparam logic [2:0] LS_B = 3'b000;
   localparam logic [2:0] LS_H = 3'b001;
   localparam logic [2:0] LS_W = 3'b010;
   localparam logic [2:0] LS_BU = 3'b100;
   localparam logic [2:0] LS_HU = 3'b101;
   typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} lsu_state_t;
   // funct3[1:0] alone encodes the access size for every legal encoding
   function automatic logic aligned(input logic [2:0] f, input logic [1:0] off);
      return f[1:0] == 2'b00 ? 1'b1 : f[1:0] == 2'b01 ? !off[0] : f[1:0] == 2'b10 ? off == 2'b00 : 1'b0;
   endfunction
   function automatic logic load_ok(input logic [2:0] f, input logic [1:0] off);
      return (f == LS_B || f == LS_H || f == LS_W || f == LS_BU || f == LS_HU) && aligned(f, off);
   endfunction
   function automatic logic store_ok(input logic [2:0] f, input logic [1:0] off);
      return (f == LS_B || f == LS_H || f == LS_W) && aligned(f, off);
   endfunction
   function automatic logic [3:0] store_be(input logic [2:0] f, input logic [1:0] off);
      return f[1:0] == 2'b00 ? 4'b0001 << off : f[1:0] == 2'b01 ? 4'b0011 << off : 4'b1111;
   endfunction
   function automatic logic [XLEN-1:0] store_wdata(input logic [2:0] f, input logic [XLEN-1:0] d);
      return f[1:0] == 2'b00 ? {4{d[7:0]}} : f[1:0] == 2'b01 ? {2{d[15:0]}} : d;
   endfunction
endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: data-memory request/response bus between the LSU and memory.
interface load_store_unit_if
   import load_store_unit_pkg::*;
#(
   parameter int DATA_WIDTH = XLEN
);
   logic dmem_req_valid;
   logic dmem_req_ready;
   logic dmem_we;
   logic [3:0] dmem_be;
   logic [DATA_WIDTH-1:0] dmem_addr;
   logic [DATA_WIDTH-1:0] dmem_wdata;
   logic dmem_rsp_valid;
   logic [DATA_WIDTH-1:0] dmem_rdata;
   modport master (
      output dmem_req_valid, dmem_we, dmem_be, dmem_addr, dmem_wdata,
      input dmem_req_ready, dmem_rsp_valid, dmem_rdata
   );
   modport slave (
      input dmem_req_valid, dmem_we, dmem_be, dmem_addr, dmem_wdata,
      output dmem_req_ready, dmem_rsp_valid, dmem_rdata
   );
endinterface

// File: rtl/load_store_unit_formatter.sv
// load_formatter: aligns the addressed byte/half of a read word and sign/zero-extends it.
module load_formatter
   import load_store_unit_pkg::*;
(
   input  logic [XLEN-1:0] rdata,
   input  logic [1:0]      offset,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] load_data
);
   logic [XLEN-1:0] s;
   always_comb begin
      s = rdata >> {offset, 3'b000};
      load_data = funct3 == LS_B  ? {{24{s[7]}}, s[7:0]}
                : funct3 == LS_H  ? {{16{s[15]}}, s[15:0]}
                : funct3 == LS_BU ? {24'b0, s[7:0]}
                : funct3 == LS_HU ? {16'b0, s[15:0]}
                : s;
   end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory stage running one dmem transaction per load/store and stalling the core meanwhile.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int DATA_WIDTH = XLEN,
   parameter int TIMEOUT_CYCLES = LSU_TIMEOUT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic [2:0]            funct3,
   input  logic [DATA_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] store_data,
   output logic [DATA_WIDTH-1:0] load_data,
   output logic                  stall,
   output logic                  done,
   output logic                  fault,
   output logic                  bus_err,
   load_store_unit_if.master     dmem
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
   lsu_state_t state;
   logic [CW-1:0] cnt;
   logic [2:0] f3;
   logic [1:0] off;
   logic legal;
   logic [DATA_WIDTH-1:0] formatted;
   load_formatter u_fmt (
      .rdata(dmem.dmem_rdata),
      .offset(off),
      .funct3(f3),
      .load_data(formatted)
   );
   always_comb begin
      legal = (mem_read ^ mem_write) && (mem_read ? load_ok(funct3, addr[1:0]) : store_ok(funct3, addr[1:0]));
      stall = state == REQ || state == WAIT_RSP || (state == IDLE && legal);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt <= '0;
         f3 <= '0;
         off <= '0;
         load_data <= '0;
         done <= 1'b0;
         fault <= 1'b0;
         bus_err <= 1'b0;
         dmem.dmem_req_valid <= 1'b0;
         dmem.dmem_we <= 1'b0;
         dmem.dmem_be <= '0;
         dmem.dmem_addr <= '0;
         dmem.dmem_wdata <= '0;
      end else begin
         done <= 1'b0;
         fault <= 1'b0;
         bus_err <= 1'b0;
         case (state)
            IDLE: begin
               if (legal) begin
                  state <= REQ;
                  f3 <= funct3;
                  off <= addr[1:0];
                  dmem.dmem_req_valid <= 1'b1;
                  dmem.dmem_we <= mem_write;
                  dmem.dmem_be <= mem_write ? store_be(funct3, addr[1:0]) : 4'b1111;
                  dmem.dmem_addr <= {addr[DATA_WIDTH-1:2], 2'b00};
                  dmem.dmem_wdata <= mem_write ? store_wdata(funct3, store_data) : '0;
               end else if (mem_read || mem_write) begin
                  fault <= 1'b1;
               end
            end
            REQ: begin
               if (dmem.dmem_req_ready) begin
                  dmem.dmem_req_valid <= 1'b0;
                  cnt <= '0;
                  state <= dmem.dmem_we ? DONE : WAIT_RSP;
                  done <= dmem.dmem_we;
               end
            end
            WAIT_RSP: begin
               // a response in the timeout cycle still completes normally
               if (dmem.dmem_rsp_valid) begin
                  load_data <= formatted;
                  state <= DONE;
                  done <= 1'b1;
               end else if (cnt == LAST) begin
                  load_data <= '0;
                  bus_err <= 1'b1;
                  state <= DONE;
                  done <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vectors feeding a request/response scoreboard for the LSU.
module tb_load_store_unit;
   import load_store_unit_pkg::*;
   typedef struct {logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] wdata;} req_t;
   typedef struct {bit flt; bit berr; bit chk_ld; logic [31:0] ld;} rsp_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic mem_read = 1'b0, mem_write = 1'b0;
   logic [2:0] funct3 = '0;
   logic [31:0] addr = '0, store_data = '0, load_data;
   logic stall, done, fault, bus_err;
   int n_cmp = 0, n_err = 0;
   req_t req_q[$];
   rsp_t rsp_q[$];
   load_store_unit_if bus ();
   load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
      .funct3(funct3), .addr(addr), .store_data(store_data), .load_data(load_data),
      .stall(stall), .done(done), .fault(fault), .bus_err(bus_err), .dmem(bus)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic fail(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: event with no expectation queued", name);
   endtask
   // scoreboard monitor
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.dmem_req_valid) begin
            if (req_q.size() == 0) fail("req_unexpected");
            else begin
               chk("req_we", bus.dmem_we, req_q[0].we);
               chk("req_be", bus.dmem_be, req_q[0].be);
               chk("req_addr", bus.dmem_addr, req_q[0].addr);
               chk("req_wdata", bus.dmem_wdata, req_q[0].wdata);
               if (bus.dmem_req_ready) void'(req_q.pop_front());
            end
         end
         if (done || fault) begin
            if (rsp_q.size() == 0) fail("rsp_unexpected");
            else begin
               rsp_t r;
               r = rsp_q.pop_front();
               chk("fault", fault, r.flt);
               chk("done", done, !r.flt);
               chk("bus_err", bus_err, r.berr);
               if (r.chk_ld) chk("load_data", load_data, r.ld);
            end
         end
      end
   end
   task automatic chk_zero(input string tag);
      chk({tag, "_load_data"}, load_data, 0);
      chk({tag, "_flags"}, {stall, done, fault, bus_err}, 0);
      chk({tag, "_req_valid"}, bus.dmem_req_valid, 0);
      chk({tag, "_we"}, bus.dmem_we, 0);
      chk({tag, "_be"}, bus.dmem_be, 0);
      chk({tag, "_addr"}, bus.dmem_addr, 0);
      chk({tag, "_wdata"}, bus.dmem_wdata, 0);
   endtask
   task automatic xact(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] rdata, input int rdy_dly, input int rsp_dly,
                       input bit flt, input bit berr, input logic [31:0] ld, input logic [3:0] be_e,
                       input logic [31:0] wd_e, input int lat);
      int cyc, nreq, nwait, stl;
      bit seen;
      if (flt) rsp_q.push_back('{1'b1, 1'b0, 1'b0, 32'h0});
      else begin
         req_q.push_back('{wr, be_e, {a[31:2], 2'b00}, wd_e});
         rsp_q.push_back('{1'b0, berr, rd, ld});
      end
      mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = d;
      bus.dmem_req_ready = 1'b0; bus.dmem_rsp_valid = 1'b0; bus.dmem_rdata = rdata;
      #1;
      chk("stall_idle", stall, !flt);
      cyc = 1; stl = stall ? 1 : 0; nreq = 0; nwait = 0; seen = 0;
      while (cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         if (done || fault) break;
         stl += stall ? 1 : 0;
         if (bus.dmem_req_valid) begin
            seen = 1; nreq++;
            bus.dmem_req_ready = nreq > rdy_dly;
         end else begin
            bus.dmem_req_ready = 1'b0;
            if (seen) begin
               nwait++;
               bus.dmem_rsp_valid = rsp_dly >= 0 && nwait > rsp_dly;
            end
         end
      end
      chk("latency", cyc, lat);
      chk("stall_cycles", stl, flt ? 0 : lat - 1);
      chk("stall_end", stall, 0);
      if (flt) chk("fault_noreq", bus.dmem_req_valid, 0);
      mem_read = 0; mem_write = 0;
      bus.dmem_req_ready = 1'b0; bus.dmem_rsp_valid = 1'b0;
      @(posedge clk); #1;
   endtask
   initial begin
      bus.dmem_req_ready = 1'b0; bus.dmem_rsp_valid = 1'b0; bus.dmem_rdata = '0;
      #12;
      chk_zero("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      //   rd wr f3     addr          data          rdata         rdy rsp flt be load_data     be       wdata         lat
      xact(0, 1, LS_W, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0,        0, -1, 0, 0, 32'h0,        4'b1111, 32'hDEAD_BEEF, 3);
      xact(0, 1, LS_B, 32'h0000_1003, 32'h0000_00A5, 32'h0,        0, -1, 0, 0, 32'h0,        4'b1000, 32'hA5A5_A5A5, 3);
      xact(0, 1, LS_B, 32'h0000_1001, 32'hFFFF_FF3C, 32'h0,        0, -1, 0, 0, 32'h0,        4'b0010, 32'h3C3C_3C3C, 3);
      xact(0, 1, LS_H, 32'h0000_1002, 32'h1234_BEEF, 32'h0,        0, -1, 0, 0, 32'h0,        4'b1100, 32'hBEEF_BEEF, 3);
      xact(1, 0, LS_B, 32'h0000_2001, 32'h0,        32'h1234_8056, 0, 0,  0, 0, 32'hFFFF_FF80, 4'b1111, 32'h0,         4);
      xact(1, 0, LS_BU, 32'h0000_2001, 32'h0,       32'h1234_8056, 0, 0,  0, 0, 32'h0000_0080, 4'b1111, 32'h0,         4);
      xact(1, 0, LS_HU, 32'h0000_2002, 32'h0,       32'h1234_8056, 0, 0,  0, 0, 32'h0000_1234, 4'b1111, 32'h0,         4);
      xact(1, 0, LS_H, 32'h0000_2000, 32'h0,        32'h1234_8056, 0, 0,  0, 0, 32'hFFFF_8056, 4'b1111, 32'h0,         4);
      xact(1, 0, LS_B, 32'h0000_2003, 32'h0,        32'h1234_8056, 0, 0,  0, 0, 32'h0000_0012, 4'b1111, 32'h0,         4);
      xact(1, 0, LS_W, 32'h0000_3002, 32'h0,        32'h0,         0, 0,  1, 0, 32'h0,        4'b0,    32'h0,         2);
      xact(1, 1, LS_W, 32'h0000_3000, 32'h0,        32'h0,         0, 0,  1, 0, 32'h0,        4'b0,    32'h0,         2);
      xact(1, 0, LS_H, 32'h0000_2001, 32'h0,        32'h0,         0, 0,  1, 0, 32'h0,        4'b0,    32'h0,         2);
      xact(1, 0, 3'b011, 32'h0000_3000, 32'h0,      32'h0,         0, 0,  1, 0, 32'h0,        4'b0,    32'h0,         2);
      xact(0, 1, LS_BU, 32'h0000_3000, 32'h0,       32'h0,         0, 0,  1, 0, 32'h0,        4'b0,    32'h0,         2);
      xact(0, 1, LS_W, 32'h0000_3001, 32'h0,        32'h0,         0, 0,  1, 0, 32'h0,        4'b0,    32'h0,         2);
      xact(1, 0, LS_W, 32'h0000_4000, 32'h0,        32'hCAFE_F00D, 5, 2,  0, 0, 32'hCAFE_F00D, 4'b1111, 32'h0,         11);
      xact(1, 0, LS_W, 32'h0000_6004, 32'h0,        32'h0BAD_F00D, 0, 3,  0, 0, 32'h0BAD_F00D, 4'b1111, 32'h0,         7);
      // reset in WAIT_RSP while load_data still holds the last load
      req_q.push_back('{1'b0, 4'b1111, 32'h0000_5000, 32'h0});
      mem_read = 1; funct3 = LS_W; addr = 32'h0000_5000; bus.dmem_req_ready = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      bus.dmem_req_ready = 1'b0;
      chk("pre_reset_stall", stall, 1);
      @(posedge clk); #1;
      rst_n = 1'b0; mem_read = 0;
      #1;
      chk_zero("midreset");
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      xact(0, 1, LS_W, 32'h0000_7000, 32'h0102_0304, 32'h0,        0, -1, 0, 0, 32'h0,        4'b1111, 32'h0102_0304, 3);
      xact(1, 0, LS_W, 32'h0000_8000, 32'h0,        32'h0,         0, -1, 0, 1, 32'h0,        4'b1111, 32'h0,         7);
      repeat (3) @(posedge clk);
      #1;
      chk("req_q_left", req_q.size(), 0);
      chk("rsp_q_left", rsp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
